// File: rtl/seg7_pkg.sv
// Shared types for the 7-segment frame arbiter: digit geometry, FSM states, frame layout.
// Pure declarations, no timing or flow control.
package seg7_pkg;

  localparam int SEG7_DIGITS = 8;
  localparam int SEG7_NIB_W  = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } seg7_state_e;

  typedef struct packed {
    logic [SEG7_DIGITS*SEG7_NIB_W-1:0] data;
    logic [SEG7_DIGITS-1:0]            dp;
    logic [SEG7_DIGITS-1:0]            blank;
    logic [SEG7_DIGITS-1:0]            blink;
  } seg7_frame_t;

  // Digit k (k>=1) is dark when it and every higher nibble are zero; digit 0 always shows.
  function automatic logic [SEG7_DIGITS-1:0] seg7_lzb_mask(
    input logic [SEG7_DIGITS*SEG7_NIB_W-1:0] data
  );
    logic [SEG7_DIGITS-1:0] m;
    m = '0;
    for (int k = 1; k < SEG7_DIGITS; k++) begin
      m[k] = ((data >> (SEG7_NIB_W * k)) == '0);
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_blink_gen.sv
// Free-running blink phase: toggles every BLINK_DIV cycles, starts at 0 out of reset.
// Latency: phase is a flop output; no backpressure, never stalls.
module seg7_blink_gen #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic clk_50m,
  input  logic reset,
  output logic phase
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/seg7_frame_arb.sv
// Round-robin owner of the 7-seg driver with min hold time and blinking; SEG7_LZB_EN adds leading-zero blanking.
// Latency: frame visible one cycle after transfer; in HOLD only the owner sees ready, others wait.
module seg7_frame_arb
  import seg7_pkg::*;
#(
  parameter int HOLD_CYC  = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic                               clk_50m,
  input  logic                               reset,
  input  logic                               req0_valid,
  output logic                               req0_ready,
  input  logic [SEG7_DIGITS*SEG7_NIB_W-1:0]  req0_data,
  input  logic [SEG7_DIGITS-1:0]             req0_dp,
  input  logic [SEG7_DIGITS-1:0]             req0_blank,
  input  logic [SEG7_DIGITS-1:0]             req0_blink,
  input  logic                               req1_valid,
  output logic                               req1_ready,
  input  logic [SEG7_DIGITS*SEG7_NIB_W-1:0]  req1_data,
  input  logic [SEG7_DIGITS-1:0]             req1_dp,
  input  logic [SEG7_DIGITS-1:0]             req1_blank,
  input  logic [SEG7_DIGITS-1:0]             req1_blink,
  output logic [SEG7_DIGITS*SEG7_NIB_W-1:0]  o_data,
  output logic [SEG7_DIGITS-1:0]             o_dp,
  output logic [SEG7_DIGITS-1:0]             o_turn_off,
  output logic                               o_owner,
  output logic                               o_hold
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  seg7_state_e            state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   last_grant_q, last_grant_d;
  logic                   owner_q, owner_d;
  seg7_frame_t            frame_q, frame_d;
  logic [SEG7_DIGITS-1:0] turn_off_q, turn_off_d;
  logic [SEG7_DIGITS-1:0] lzb_mask;
  logic                   blink_phase;
  logic                   xfer0, xfer1;
  seg7_frame_t            frame0, frame1;

  assign frame0 = '{data: req0_data, dp: req0_dp, blank: req0_blank, blink: req0_blink};
  assign frame1 = '{data: req1_data, dp: req1_dp, blank: req1_blank, blink: req1_blink};

  seg7_blink_gen #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk_50m (clk_50m),
    .reset   (reset),
    .phase   (blink_phase)
  );

  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    frame_d      = frame_q;
    lzb_mask     = '0;

    case (state_q)
      ST_IDLE: begin
        req0_ready = req0_valid && (!req1_valid || last_grant_q);
        req1_ready = req1_valid && (!req0_valid || !last_grant_q);
      end
      ST_HOLD: begin
        req0_ready = !owner_q;
        req1_ready = owner_q;
      end
      default: ;
    endcase

    // Nobody is granted while reset is held, even though the state already reads IDLE.
    if (reset) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end

    xfer0 = req0_valid && req0_ready;
    xfer1 = req1_valid && req1_ready;

    if (xfer0 || xfer1) begin
      frame_d      = xfer1 ? frame1 : frame0;
      owner_d      = xfer1;
      last_grant_d = xfer1;
      hold_cnt_d   = HOLD_LOAD;
      state_d      = ST_HOLD;
    end else if (state_q == ST_HOLD) begin
      if (hold_cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
    end

`ifdef SEG7_LZB_EN
    lzb_mask = seg7_lzb_mask(frame_d.data);
`else
    lzb_mask = '0;
`endif

    turn_off_d = frame_d.blank | (frame_d.blink & {SEG7_DIGITS{blink_phase}}) | lzb_mask;
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      // Reset frame is fully blanked so an idle display stays dark until the first transfer.
      frame_q      <= '{data: '0, dp: '0, blank: '1, blink: '0};
      turn_off_q   <= '1;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      frame_q      <= frame_d;
      turn_off_q   <= turn_off_d;
    end
  end

  assign o_data     = frame_q.data;
  assign o_dp       = frame_q.dp;
  assign o_turn_off = turn_off_q;
  assign o_owner    = owner_q;
  assign o_hold     = (state_q == ST_HOLD);

endmodule

// File: tb/tb_seg7_frame_arb.sv
// Directed bench for seg7_frame_arb with HOLD_CYC=8, BLINK_DIV=4; expectations follow SEG7_LZB_EN.
module tb_seg7_frame_arb;

  logic        clk_50m = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data, o_data;
  logic [7:0]  req0_dp, req0_blank, req0_blink;
  logic [7:0]  req1_dp, req1_blank, req1_blink;
  logic [7:0]  o_dp, o_turn_off;
  logic        o_owner, o_hold;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SEG7_LZB_EN
  localparam logic [7:0] LZB_ON = 8'hFF;
`else
  localparam logic [7:0] LZB_ON = 8'h00;
`endif

  always #10 clk_50m = ~clk_50m;

  seg7_frame_arb #(
    .HOLD_CYC  (8),
    .BLINK_DIV (4)
  ) dut (
    .clk_50m    (clk_50m),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_dp    (req0_dp),
    .req0_blank (req0_blank),
    .req0_blink (req0_blink),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_dp    (req1_dp),
    .req1_blank (req1_blank),
    .req1_blink (req1_blink),
    .o_data     (o_data),
    .o_dp       (o_dp),
    .o_turn_off (o_turn_off),
    .o_owner    (o_owner),
    .o_hold     (o_hold)
  );

  function automatic logic [7:0] exp_lzb(input logic [31:0] d);
    logic [7:0] m;
    logic       zero;
    m    = 8'h00;
    zero = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      zero = zero && (d[4*k +: 4] == 4'h0);
      m[k] = zero;
    end
    return m & LZB_ON;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_dp = '0; req0_blank = '0; req0_blink = '0;
    req1_valid = 1'b0; req1_data = '0; req1_dp = '0; req1_blank = '0; req1_blink = '0;

    // Reset state
    step(); step(); step();
    chk("rst_data", o_data, 32'h0);
    chk("rst_dp", o_dp, 8'h00);
    chk("rst_toff", o_turn_off, 8'hFF);
    chk("rst_owner", o_owner, 1'b0);
    chk("rst_hold", o_hold, 1'b0);
    chk("rst_r0", req0_ready, 1'b0);
    chk("rst_r1", req1_ready, 1'b0);
    reset = 1'b0;
    step(); step();
    chk("idle_toff", o_turn_off, 8'hFF);
    chk("idle_r0", req0_ready, 1'b0);

    // Tie from reset goes to req0; req1 waits exactly 8 cycles
    req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_dp = 8'h81;
    req1_valid = 1'b1; req1_data = 32'hAAAA_5555; req1_dp = 8'h00; req1_blank = 8'hF0;
    #1;
    chk("tie_r0", req0_ready, 1'b1);
    chk("tie_r1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    #1;
    chk("a_data", o_data, 32'h1234_5678);
    chk("a_dp", o_dp, 8'h81);
    chk("a_owner", o_owner, 1'b0);
    chk("a_toff", o_turn_off, exp_lzb(32'h1234_5678));
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk("a_hold", o_hold, 1'b1);
      chk("a_r1_wait", req1_ready, 1'b0);
    end
    step();
    chk("a_expire", o_hold, 1'b0);
    chk("a_r1_go", req1_ready, 1'b1);
    step();
    chk("b_data", o_data, 32'hAAAA_5555);
    chk("b_owner", o_owner, 1'b1);
    chk("b_hold", o_hold, 1'b1);
    chk("b_toff", o_turn_off, 8'hF0 | exp_lzb(32'hAAAA_5555));

    // req1 owns; req0 waits while req1 rewrites mid-hold
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h8765_4321; req0_dp = 8'h00;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      chk("c_hold", o_hold, 1'b1);
      chk("c_r0_wait", req0_ready, 1'b0);
    end
    req1_valid = 1'b1; req1_data = 32'hCAFE_0001; req1_blank = 8'h00;
    #1;
    chk("c_rw_r1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    #1;
    chk("c_rw_data", o_data, 32'hCAFE_0001);
    chk("c_rw_hold", o_hold, 1'b1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("c_rw_hold", o_hold, 1'b1);
      chk("c_rw_r0_wait", req0_ready, 1'b0);
    end
    step();
    chk("c_expire", o_hold, 1'b0);
    chk("c_r0_go", req0_ready, 1'b1);
    step();
    chk("c_data", o_data, 32'h8765_4321);
    chk("c_owner", o_owner, 1'b0);

    // Reset in the middle of req0's hold with req1 pending
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h0000_0120; req1_dp = 8'h00; req1_blank = 8'h00; req1_blink = 8'h01;
    #1;
    chk("d_r1_wait", req1_ready, 1'b0);
    step(); step();
    chk("d_hold", o_hold, 1'b1);
    reset = 1'b1;
    step();
    chk("d_rst_data", o_data, 32'h0);
    chk("d_rst_dp", o_dp, 8'h00);
    chk("d_rst_toff", o_turn_off, 8'hFF);
    chk("d_rst_owner", o_owner, 1'b0);
    chk("d_rst_hold", o_hold, 1'b0);
    chk("d_rst_r1", req1_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("d_post_r1", req1_ready, 1'b1);
    chk("d_post_r0", req0_ready, 1'b0);
    step();
    req1_valid = 1'b0;
    chk("d_data", o_data, 32'h0000_0120);
    chk("d_owner", o_owner, 1'b1);

    // Digit 0 blinks: shown for 4 cycles, dark for 4, shown again
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) step();
      chk("blink_toff", o_turn_off,
          exp_lzb(32'h0000_0120) | ((((n - 1) / 4) % 2) != 0 ? 8'h01 : 8'h00));
    end

    // All-zero data: only leading-zero blanking can darken digits
    req0_valid = 1'b1; req0_data = 32'h0; req0_dp = 8'h01; req0_blank = 8'h00; req0_blink = 8'h00;
    #1;
    chk("e_r0", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    chk("e_toff", o_turn_off, exp_lzb(32'h0));
    chk("e_dp", o_dp, 8'h01);
    chk("e_owner", o_owner, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
